// File: rtl/sw_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sw_scan_ctrl
// Brief    : Sequencer for the 2x2 device-select switch bank (11/12/21/22).
//            Walks enabled devices in order: close switch, settle, sample
//            handshake with the readout, open switch, guard gap.
//            Break-before-make: at most one switch output high per cycle.
// Options  : SW_SCAN_DEBOUNCE_EN - debounce the synchronized push-key for
//            DB_CYC stable cycles before its rising edge requests a scan.
// Revision : 1.0 - initial release
// ============================================================================
module sw_scan_ctrl #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned GUARD_CYC   = 4,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DB_CYC      = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_state,
  input  logic       start,
  input  logic [3:0] dev_mask,
  input  logic       sample_ack,
  output logic       device11,
  output logic       device12,
  output logic       device21,
  output logic       device22,
  output logic [1:0] dev_idx,
  output logic       sample_req,
  output logic       busy,
  output logic       done,
  output logic [3:0] timeout_err
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_GUARD  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pending;   // latched mask with visited devices removed
  logic [3:0]       sw;        // one-hot switch enables {22,21,12,11}
  logic             key_s1;
  logic             key_s2;
  logic             key_rise;
  logic             req;
  logic             found;
  logic [1:0]       next_idx;

  // Two-flop synchronizer for the asynchronous key level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= key_state;
      key_s2 <= key_s1;
    end
  end

`ifdef SW_SCAN_DEBOUNCE_EN
  localparam int unsigned DB_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            db_prev;

  // Debounced level follows the key only after DB_CYC consecutive differing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (key_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= key_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign key_rise = db_level & ~db_prev;
`else
  logic key_prev;
  logic unused_db_cfg;

  // Previous synchronized key level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_prev <= 1'b0;
    else        key_prev <= key_s2;
  end

  assign key_rise      = key_s2 & ~key_prev;
  assign unused_db_cfg = (DB_CYC != 0);
`endif

  assign req = start | key_rise;

  // Lowest-index device still pending in this scan
  always_comb begin
    found    = 1'b0;
    next_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        found    = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  // Scan sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pending     <= 4'b0;
      sw          <= 4'b0;
      dev_idx     <= 2'd0;
      sample_req  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 4'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            pending     <= dev_mask;
            timeout_err <= 4'b0;
            busy        <= 1'b1;
            state       <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (found) begin
            dev_idx           <= next_idx;
            pending[next_idx] <= 1'b0;
            sw                <= 4'b0001 << next_idx;
            cnt               <= '0;
            state             <= ST_SETTLE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt        <= '0;
            sample_req <= 1'b1;
            state      <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          // Ack takes priority over a timeout expiring in the same cycle
          if (sample_ack || (cnt == ACK_LAST)) begin
            if (!sample_ack) timeout_err[dev_idx] <= 1'b1;
            sample_req <= 1'b0;
            sw         <= 4'b0;
            cnt        <= '0;
            state      <= ST_GUARD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            cnt   <= '0;
            state <= ST_SELECT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          sw         <= 4'b0;
          sample_req <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign device11 = sw[0];
  assign device12 = sw[1];
  assign device21 = sw[2];
  assign device22 = sw[3];

endmodule
`default_nettype wire

// File: tb/tb_sw_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_scan_ctrl
// Brief    : Directed self-checking bench for sw_scan_ctrl
//            (SETTLE_CYC=4, GUARD_CYC=2, ACK_TIMEOUT=16, DB_CYC=10).
//            Key test uses SW_SCAN_DEBOUNCE_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_scan_ctrl;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned GUARD  = 2;
  localparam int unsigned ACKTO  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_state;
  logic       start;
  logic [3:0] dev_mask;
  logic       sample_ack;
  logic       device11, device12, device21, device22;
  logic [1:0] dev_idx;
  logic       sample_req, busy, done;
  logic [3:0] timeout_err;
  logic [3:0] sw;

  int n_checks = 0;
  int n_err    = 0;

  assign sw = {device22, device21, device12, device11};

  sw_scan_ctrl #(
    .SETTLE_CYC (SETTLE),
    .GUARD_CYC  (GUARD),
    .ACK_TIMEOUT(ACKTO),
    .CNT_W      (16),
    .DB_CYC     (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_state  (key_state),
    .start      (start),
    .dev_mask   (dev_mask),
    .sample_ack (sample_ack),
    .device11   (device11),
    .device12   (device12),
    .device21   (device21),
    .device22   (device22),
    .dev_idx    (dev_idx),
    .sample_req (sample_req),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the first SETTLE cycle of device idx; returns in the SELECT
  // cycle that follows its guard gap. ack_lat=0 means no ack is ever given.
  task automatic do_device(input int idx, input int ack_lat);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    check($sformatf("dev%0d_settle_sw", idx), 32'(sw), 32'(onehot));
    check($sformatf("dev%0d_idx", idx), 32'(dev_idx), 32'(idx));
    check($sformatf("dev%0d_busy", idx), 32'(busy), 32'd1);
    repeat (SETTLE - 1) tick();
    check($sformatf("dev%0d_req_late_settle", idx), 32'(sample_req), 32'd0);
    tick();
    check($sformatf("dev%0d_req_rise", idx), 32'(sample_req), 32'd1);
    check($sformatf("dev%0d_sample_sw", idx), 32'(sw), 32'(onehot));
    if (ack_lat > 0) begin
      repeat (ack_lat - 1) tick();
      check($sformatf("dev%0d_req_before_ack", idx), 32'(sample_req), 32'd1);
      sample_ack = 1'b1;
      tick();
      sample_ack = 1'b0;
    end else begin
      repeat (ACKTO - 1) tick();
      check($sformatf("dev%0d_req_last_wait", idx), 32'(sample_req), 32'd1);
      tick();
    end
    check($sformatf("dev%0d_req_drop", idx), 32'(sample_req), 32'd0);
    check($sformatf("dev%0d_sw_drop", idx), 32'(sw), 32'd0);
    for (int g = 0; g < int'(GUARD); g++) begin
      tick();
      check($sformatf("dev%0d_gap_sw", idx), 32'(sw), 32'd0);
    end
  endtask

  initial begin
    int starts;
    logic busy_prev;
    rst_n = 1'b0; key_state = 1'b0; start = 1'b0; dev_mask = 4'h0; sample_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sw", 32'(sw), 32'd0);
    check("rst_req", 32'(sample_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(dev_idx), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full mask, ack 3 cycles after each request
    dev_mask = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_accept_busy", 32'(busy), 32'd1);
    check("t1_select_sw", 32'(sw), 32'd0);
    tick(); do_device(0, 3);
    tick(); do_device(1, 3);
    tick(); do_device(2, 3);
    tick(); do_device(3, 3);
    tick();
    check("t1_done_state_done", 32'(done), 32'd0);
    check("t1_done_state_busy", 32'(busy), 32'd1);
    tick();
    check("t1_done_pulse", 32'(done), 32'd1);
    check("t1_busy_clear", 32'(busy), 32'd0);
    check("t1_terr", 32'(timeout_err), 32'd0);
    tick();
    check("t1_done_single", 32'(done), 32'd0);

    // Sparse mask; restart and mask change during the scan are ignored
    dev_mask = 4'b0101; start = 1'b1;
    tick();
    start = 1'b1; dev_mask = 4'hF;
    tick();
    start = 1'b0;
    do_device(0, 2);
    tick(); do_device(2, 5);
    tick();
    tick();
    check("t2_done_pulse", 32'(done), 32'd1);
    check("t2_terr", 32'(timeout_err), 32'd0);
    tick();
    check("t2_no_queued_scan", 32'(busy), 32'd0);
    tick();
    check("t2_still_idle", 32'(busy), 32'd0);

    // No ack: timeout on device 12
    dev_mask = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); do_device(1, 0);
    tick();
    tick();
    check("t3_done_pulse", 32'(done), 32'd1);
    check("t3_terr", 32'(timeout_err), 32'b0010);
    tick();
    check("t3_terr_sticky", 32'(timeout_err), 32'b0010);

    // Ack on the timeout-expiry cycle counts as an ack
    dev_mask = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    check("t3b_terr_cleared", 32'(timeout_err), 32'd0);
    tick(); do_device(3, ACKTO);
    tick();
    tick();
    check("t3b_done_pulse", 32'(done), 32'd1);
    check("t3b_terr", 32'(timeout_err), 32'd0);
    tick();

    // Empty mask: done three cycles after the request, no switch
    dev_mask = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_sw_a", 32'(sw), 32'd0);
    tick();
    check("t4_done_early", 32'(done), 32'd0);
    check("t4_sw_b", 32'(sw), 32'd0);
    tick();
    check("t4_done_pulse", 32'(done), 32'd1);
    check("t4_busy_clear", 32'(busy), 32'd0);
    check("t4_sw_c", 32'(sw), 32'd0);
    tick();

`ifdef SW_SCAN_DEBOUNCE_EN
    // 9-cycle glitch is rejected, 12-cycle hold starts exactly one scan
    starts = 0; busy_prev = busy;
    for (int c = 0; c < 80; c++) begin
      key_state = (c < 9) || (c >= 25 && c < 37);
      tick();
      if (busy && !busy_prev) starts++;
      busy_prev = busy;
      if (c == 24) check("t6_glitch_ignored", 32'(starts), 32'd0);
    end
    key_state = 1'b0;
    check("t6_one_scan", 32'(starts), 32'd1);
`else
    // Key rise reaches the sequencer on the third edge; held level does not retrigger
    key_state = 1'b1;
    tick(); tick();
    check("t6_key_not_yet", 32'(busy), 32'd0);
    tick();
    check("t6_key_accept", 32'(busy), 32'd1);
    starts = 0; busy_prev = busy;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy && !busy_prev) starts++;
      busy_prev = busy;
    end
    check("t6_key_no_retrigger", 32'(starts), 32'd0);
    check("t6_key_idle", 32'(busy), 32'd0);
    key_state = 1'b0;
    repeat (4) tick();
`endif

    // Asynchronous reset while device 12 is sampling
    dev_mask = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); do_device(0, 1);
    tick();
    repeat (SETTLE) tick();
    check("t5_pre_req", 32'(sample_req), 32'd1);
    check("t5_pre_sw", 32'(sw), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_sw", 32'(sw), 32'd0);
    check("t5_async_req", 32'(sample_req), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_idx", 32'(dev_idx), 32'd0);
    check("t5_async_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_sw", 32'(sw), 32'd0);
    check("t5_idle_req", 32'(sample_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
